// File: rtl/timing_nco_ctrl_pkg.sv
// Shared constants, types and saturation helper for the symbol-timing NCO.
// Used by timing_nco_ctrl, its loop filter and its port interface.
package msk_timing_pkg;

    localparam int OSF      = 20;
    localparam int SPS_LOG2 = 2;
    localparam int ACC_W    = 32;
    localparam int ERR_W    = 16;
    localparam int KP_SHL   = 12;
    localparam int KI_SHL   = 4;
    localparam int STEP_LIM = 2**26;
    localparam int LOCK_THR = 512;
    localparam int LOCK_CNT = 64;

    localparam int PH_W   = 5;
    localparam int MU_W   = 27;
    localparam int FRAC_W = 32;
    localparam int PROD_W = FRAC_W + PH_W;
    localparam int CNT_W  = 7;

    typedef logic [ACC_W-1:0]        step_t;
    typedef logic signed [ERR_W-1:0] err_t;
    typedef logic signed [ACC_W:0]   sacc_t;

    localparam step_t STEP_NOM = step_t'(1) << (ACC_W - SPS_LOG2);
    localparam sacc_t LIM_S    = sacc_t'(STEP_LIM);

    function automatic sacc_t sat(input sacc_t v, input sacc_t lim);
        sacc_t r;
        if (v > lim)
            r = lim;
        else if (v < -lim)
            r = -lim;
        else
            r = v;
        return r;
    endfunction

endpackage

// File: rtl/timing_nco_ctrl_if.sv
// Port bundle between the TED / interpolator side and the timing NCO.
// slave is the controller view, master the driver view.
interface timing_nco_ctrl_if
    import msk_timing_pkg::*;
();

    logic            iq_raw_val_i;
    err_t            ted_err_i;
    logic            ted_val_i;
    logic [PH_W-1:0] phase_int_o;
    logic [MU_W-1:0] mu_o;
    logic            phase_val_o;
    logic            sym_valid_o;
    step_t           step_o;
    logic            lock_o;

    modport master (
        output iq_raw_val_i, ted_err_i, ted_val_i,
        input  phase_int_o, mu_o, phase_val_o,
        input  sym_valid_o, step_o, lock_o
    );

    modport slave (
        input  iq_raw_val_i, ted_err_i, ted_val_i,
        output phase_int_o, mu_o, phase_val_o,
        output sym_valid_o, step_o, lock_o
    );

endinterface

// File: rtl/timing_nco_ctrl_loop_filter.sv
// PI loop filter: integrates scaled TED error and produces the
// clamped NCO step around the nominal value.
module timing_loop_filter
    import msk_timing_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  ted_val_i,
    input  err_t  ted_err_i,
    output step_t step_o
);

    sacc_t integ_q;
    sacc_t integ_nx;
    sacc_t ki_term;
    sacc_t kp_term;
    sacc_t trim;
    step_t step_nx;

    // Integrator update and proportional trim, both clamped.
    always_comb begin
        ki_term  = sacc_t'(ted_err_i) <<< KI_SHL;
        kp_term  = sacc_t'(ted_err_i) <<< KP_SHL;
        integ_nx = sat(integ_q + ki_term, LIM_S);
        trim     = sat(kp_term + integ_nx, LIM_S);
        step_nx  = step_t'(sacc_t'({1'b0, STEP_NOM}) + trim);
    end

    // Filter state only moves on a valid error sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            integ_q <= '0;
            step_o  <= STEP_NOM;
        end else if (ted_val_i) begin
            integ_q <= integ_nx;
            step_o  <= step_nx;
        end
    end

endmodule

// File: rtl/timing_nco_ctrl.sv
// Symbol-timing NCO driving the polyphase interpolator phase interface.
// Optional lock detector: define TIMING_NCO_LOCK_DET_EN.
module timing_nco_ctrl
    import msk_timing_pkg::*;
(
    input  logic clk,
    input  logic rst,
    timing_nco_ctrl_if.slave bus
);

    step_t            step_q;
    step_t            acc_q;
    logic             wrap_q;
    logic [ACC_W:0]   sum;
    logic [FRAC_W-1:0] frac;
    logic [FRAC_W-1:0] prod;
    logic [PH_W-1:0]  ph_q;
    logic [MU_W-1:0]  mu_q;
    logic             val_q;

    timing_loop_filter u_lf (
        .clk       (clk),
        .rst       (rst),
        .ted_val_i (bus.ted_val_i),
        .ted_err_i (bus.ted_err_i),
        .step_o    (step_q)
    );

    assign sum = {1'b0, acc_q} + {1'b0, step_q};

    // Stage 1: modular phase accumulator; carry marks a symbol instant.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            wrap_q <= 1'b0;
        end else if (bus.iq_raw_val_i) begin
            acc_q  <= sum[ACC_W-1:0];
            wrap_q <= sum[ACC_W];
        end else begin
            wrap_q <= 1'b0;
        end
    end

    // Residue to Q0.32 fraction (saturating), then scale by branch count.
    always_comb begin
        if (|acc_q[ACC_W-1 -: SPS_LOG2])
            frac = '1;
        else
            frac = acc_q << SPS_LOG2;
        prod = FRAC_W'((PROD_W'(frac) * PROD_W'(OSF)) >> (FRAC_W - MU_W));
    end

    // Stage 2: output register, updated only on a wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q  <= '0;
            mu_q  <= '0;
            val_q <= 1'b0;
        end else begin
            val_q <= wrap_q;
            if (wrap_q) begin
                ph_q <= prod[FRAC_W-1 -: PH_W];
                mu_q <= prod[MU_W-1:0];
            end
        end
    end

    assign bus.phase_int_o = ph_q;
    assign bus.mu_o        = mu_q;
    assign bus.phase_val_o = val_q;
    assign bus.sym_valid_o = val_q;
    assign bus.step_o      = step_q;

`ifdef TIMING_NCO_LOCK_DET_EN
    logic [CNT_W-1:0]        lock_cnt;
    logic signed [ERR_W:0]   err_x;
    logic signed [ERR_W:0]   err_mag;
    logic                    in_thr;

    // Magnitude of the error with one extra bit so -2^15 stays positive.
    always_comb begin
        err_x   = {bus.ted_err_i[ERR_W-1], bus.ted_err_i};
        err_mag = (err_x < 0) ? -err_x : err_x;
        in_thr  = (err_mag < LOCK_THR);
    end

    // Run length of small errors, saturating at the lock count.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt <= '0;
        end else if (bus.ted_val_i) begin
            if (!in_thr)
                lock_cnt <= '0;
            else if (lock_cnt != CNT_W'(LOCK_CNT))
                lock_cnt <= lock_cnt + 1'b1;
        end
    end

    assign bus.lock_o = (lock_cnt == CNT_W'(LOCK_CNT));
`else
    assign bus.lock_o = 1'b0;
`endif

endmodule

// File: tb/tb_timing_nco_ctrl.sv
// Self-checking bench for timing_nco_ctrl against an arithmetic model.
// Directed scenarios followed by a randomized run.
module tb_timing_nco_ctrl;
    import msk_timing_pkg::*;

    localparam longint MOD  = 64'd1 << 32;
    localparam longint NOM  = 64'd1 << 30;
    localparam longint LIM  = 64'd1 << 26;

    typedef struct {
        longint due;
        longint ph;
        longint mu;
    } ev_t;

    logic clk = 1'b0;
    logic rst;

    timing_nco_ctrl_if bus ();

    timing_nco_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int     vec  = 0;
    int     errs = 0;
    longint edge_n = 0;

    longint m_acc   = 0;
    longint m_step  = NOM;
    longint m_integ = 0;
    int     m_cnt   = 0;
    ev_t    evq[$];
    longint exp_val = 0;
    longint exp_ph  = 0;
    longint exp_mu  = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        vec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     tag, got, exp, edge_n);
        end
    endtask

    function automatic longint clamp(input longint v, input longint lim);
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    task automatic model(input bit r, input bit iq, input bit tv, input int err);
        longint frac;
        longint p;
        longint e;
        ev_t    ev;
        if (r) begin
            m_acc   = 0;
            m_step  = NOM;
            m_integ = 0;
            m_cnt   = 0;
            evq.delete();
            exp_val = 0;
            exp_ph  = 0;
            exp_mu  = 0;
        end else begin
            e = longint'(err);
            if (iq) begin
                m_acc = m_acc + m_step;
                if (m_acc >= MOD) begin
                    m_acc  = m_acc - MOD;
                    frac   = (m_acc >= NOM) ? MOD - 1 : m_acc * 4;
                    p      = frac * OSF;
                    ev.due = edge_n + 1;
                    ev.ph  = p / MOD;
                    ev.mu  = (p / 32) % (64'd1 << 27);
                    evq.push_back(ev);
                end
            end
            if (tv) begin
                m_integ = clamp(m_integ + e * 16, LIM);
                m_step  = NOM + clamp(e * 4096 + m_integ, LIM);
                if (e > -512 && e < 512)
                    m_cnt = (m_cnt < LOCK_CNT) ? m_cnt + 1 : LOCK_CNT;
                else
                    m_cnt = 0;
            end
            exp_val = 0;
            if (evq.size() > 0 && evq[0].due == edge_n) begin
                exp_val = 1;
                exp_ph  = evq[0].ph;
                exp_mu  = evq[0].mu;
                void'(evq.pop_front());
            end
        end
    endtask

    task automatic tick(input bit r, input bit iq, input bit tv, input int err);
        longint exp_lock;
        rst              = r;
        bus.iq_raw_val_i = iq;
        bus.ted_val_i    = tv;
        bus.ted_err_i    = err_t'(err);
        @(posedge clk);
        edge_n++;
        model(r, iq, tv, err);
        #1;
`ifdef TIMING_NCO_LOCK_DET_EN
        exp_lock = (m_cnt >= LOCK_CNT) ? 1 : 0;
`else
        exp_lock = 0;
`endif
        chk("phase_val", longint'(bus.phase_val_o), exp_val);
        chk("sym_valid", longint'(bus.sym_valid_o), exp_val);
        chk("phase_int", longint'(bus.phase_int_o), exp_ph);
        chk("mu", longint'(bus.mu_o), exp_mu);
        chk("step", longint'(bus.step_o), m_step);
        chk("lock", longint'(bus.lock_o), exp_lock);
        if (bus.phase_val_o)
            chk("phase_range", longint'(bus.phase_int_o <= 19), 1);
    endtask

    initial begin
        int err;
        bit iq;
        bit tv;
        bit r;

        // reset state
        repeat (3) tick(1, 0, 0, 0);

        // 1: sample every clock, no TED
        repeat (24) tick(0, 1, 0, 0);

        // 2: sample every 3rd clock
        repeat (3) tick(1, 0, 0, 0);
        for (int i = 0; i < 48; i++)
            tick(0, (i % 3) == 0, 0, 0);

        // 3: large positive error held
        repeat (2) tick(1, 0, 0, 0);
        repeat (60) tick(0, 1, 1, 32767);
        chk("sat_hi_step", longint'(bus.step_o), NOM + LIM);

        // 4: large negative error held
        repeat (2) tick(1, 0, 0, 0);
        repeat (60) tick(0, 1, 1, -32767);
        chk("sat_lo_step", longint'(bus.step_o), NOM - LIM);

        // 5: reset while a strobe is in flight
        repeat (2) tick(1, 0, 0, 0);
        repeat (4) tick(0, 1, 1, 1000);
        tick(1, 0, 0, 0);
        chk("rst_step", longint'(bus.step_o), NOM);
        chk("rst_strobe", longint'(bus.phase_val_o), 0);
        repeat (4) tick(0, 0, 0, 0);

`ifdef TIMING_NCO_LOCK_DET_EN
        // 6: lock acquisition and loss
        tick(1, 0, 0, 0);
        repeat (63) tick(0, 0, 1, 100);
        chk("lock_63", longint'(bus.lock_o), 0);
        tick(0, 0, 1, 100);
        chk("lock_64", longint'(bus.lock_o), 1);
        tick(0, 0, 1, 600);
        chk("lock_drop", longint'(bus.lock_o), 0);
`endif

        // randomized traffic
        tick(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 499) == 0);
            iq = ($urandom_range(0, 3) != 0);
            tv = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0)
                err = int'($urandom_range(0, 65535)) - 32768;
            else
                err = int'($urandom_range(0, 1200)) - 600;
            tick(r, iq, tv, err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
